// File: rtl/stats_pkg.sv
// Shared constants and arithmetic helpers for the RX/TX statistics meters.
package stats_pkg;

    // Preamble/SFD (8) plus inter-frame gap (12) added to every frame length.
    localparam int unsigned STATS_OVERHEAD_BYTES = 20;
    // One second at the 125 MHz MAC clock.
    localparam int unsigned STATS_WINDOW_125M    = 125_000_000;
    // Timestamp width, shared with the TX timestamp inserter and the register block.
    localparam int unsigned TS_W                 = 24;
    // Accumulator and published-counter width.
    localparam int unsigned ACC_W                = 32;
    // Per-frame byte addend: 16-bit length plus overhead needs one extra bit.
    localparam int unsigned ADD_W                = 17;

    // Saturating add of a 17-bit addend into a 32-bit accumulator; sticks at all-ones.
    function automatic logic [ACC_W-1:0] sat_add32(input logic [ACC_W-1:0] acc,
                                                   input logic [ADD_W-1:0] addend);
        logic [ACC_W:0] sum;
        sum = {1'b0, acc} + {{(ACC_W + 1 - ADD_W){1'b0}}, addend};
        if (sum[ACC_W]) begin
            return {ACC_W{1'b1}};
        end else begin
            return sum[ACC_W-1:0];
        end
    endfunction

endpackage

// File: rtl/rx_stats_meter_if.sv
// Per-frame event bus from the RX frame parser into the statistics meter.
interface rx_stats_meter_if;
    import stats_pkg::*;

    logic            frame_valid;
    logic [15:0]     frame_len;
    logic [31:0]     frame_srcip;
    logic            ts_valid;
    logic [TS_W-1:0] frame_ts;

    // Parser side drives the event.
    modport master (
        output frame_valid,
        output frame_len,
        output frame_srcip,
        output ts_valid,
        output frame_ts
    );

    // Meter side consumes the event.
    modport slave (
        input frame_valid,
        input frame_len,
        input frame_srcip,
        input ts_valid,
        input frame_ts
    );

endinterface

// File: rtl/stats_window_timer.sv
// Free-running measurement window timer. Counts 0..WINDOW-1 and raises a
// registered one-cycle boundary pulse during the cycle the count is WINDOW-1.
module stats_window_timer
    import stats_pkg::*;
#(
    parameter int unsigned WINDOW = STATS_WINDOW_125M
) (
    input  logic clk,
    input  logic rst_n,
    output logic boundary
);

    localparam int unsigned       CNT_W  = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam logic [CNT_W-1:0]  LAST_C = CNT_W'(WINDOW - 1);
    localparam logic [CNT_W-1:0]  ZERO_C = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0]  ONE_C  = CNT_W'(1);

    logic [CNT_W-1:0] win_cnt_r;
    logic [CNT_W-1:0] win_cnt_nxt_s;
    logic             boundary_r;

    // Next count: wrap to zero after the last cycle of the window.
    always_comb begin
        win_cnt_nxt_s = win_cnt_r;
        if (win_cnt_r == LAST_C) begin
            win_cnt_nxt_s = ZERO_C;
        end else begin
            win_cnt_nxt_s = win_cnt_r + ONE_C;
        end
    end

    // Count register; boundary is pre-decoded from the next count so it is a flop output
    // that is high exactly while win_cnt_r == WINDOW-1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            win_cnt_r  <= ZERO_C;
            boundary_r <= (LAST_C == ZERO_C);
        end else begin
            win_cnt_r  <= win_cnt_nxt_s;
            boundary_r <= (win_cnt_nxt_s == LAST_C);
        end
    end

    assign boundary = boundary_r;

endmodule

// File: rtl/rx_stats_meter.sv
// Per-port RX statistics: frames and bytes per window, one-way latency from the
// TX timestamp, and source IPv4 of the last frame. All outputs are flop outputs.
module rx_stats_meter
    import stats_pkg::*;
#(
    parameter int unsigned WINDOW   = STATS_WINDOW_125M,
    parameter int unsigned OVERHEAD = STATS_OVERHEAD_BYTES
) (
    input  logic              clk,
    input  logic              rst_n,
    rx_stats_meter_if.slave   frm,
    input  logic [TS_W-1:0]   global_counter,
    output logic [ACC_W-1:0]  pps,
    output logic [ACC_W-1:0]  throughput,
    output logic [TS_W-1:0]   latency,
    output logic [31:0]       ipv4_ip,
    output logic              update
);

    localparam logic [ADD_W-1:0] OVERHEAD_C = ADD_W'(OVERHEAD);
    localparam logic [ADD_W-1:0] ONE_FRAME_C = ADD_W'(1);

    logic             boundary_s;
    logic [ADD_W-1:0] addend_s;
    logic [ACC_W-1:0] acc_frames_r;
    logic [ACC_W-1:0] acc_bytes_r;
    logic [ACC_W-1:0] acc_frames_nxt_s;
    logic [ACC_W-1:0] acc_bytes_nxt_s;
    logic [ACC_W-1:0] pps_r;
    logic [ACC_W-1:0] throughput_r;
    logic [TS_W-1:0]  latency_r;
    logic [31:0]      ipv4_ip_r;
    logic             update_r;

    stats_window_timer #(
        .WINDOW (WINDOW)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .boundary (boundary_s)
    );

    // Wire-length plus preamble/IFG overhead, 17 bits so it never truncates.
    assign addend_s = {1'b0, frm.frame_len} + OVERHEAD_C;

    // Accumulator next-state: a boundary frame seeds the new window, otherwise accumulate with saturation.
    always_comb begin
        acc_frames_nxt_s = acc_frames_r;
        acc_bytes_nxt_s  = acc_bytes_r;
        if (boundary_s) begin
            if (frm.frame_valid) begin
                acc_frames_nxt_s = 32'd1;
                acc_bytes_nxt_s  = {{(ACC_W - ADD_W){1'b0}}, addend_s};
            end else begin
                acc_frames_nxt_s = 32'd0;
                acc_bytes_nxt_s  = 32'd0;
            end
        end else if (frm.frame_valid) begin
            acc_frames_nxt_s = sat_add32(acc_frames_r, ONE_FRAME_C);
            acc_bytes_nxt_s  = sat_add32(acc_bytes_r, addend_s);
        end else begin
            acc_frames_nxt_s = acc_frames_r;
            acc_bytes_nxt_s  = acc_bytes_r;
        end
    end

    // Window accumulators and the per-window published counters with their update strobe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_frames_r <= 32'd0;
            acc_bytes_r  <= 32'd0;
            pps_r        <= 32'd0;
            throughput_r <= 32'd0;
            update_r     <= 1'b0;
        end else begin
            acc_frames_r <= acc_frames_nxt_s;
            acc_bytes_r  <= acc_bytes_nxt_s;
            update_r     <= boundary_s;
            if (boundary_s) begin
                pps_r        <= acc_frames_r;
                throughput_r <= acc_bytes_r;
            end else begin
                pps_r        <= pps_r;
                throughput_r <= throughput_r;
            end
        end
    end

    // One-way latency: timebase minus TX stamp, modulo 2^TS_W so counter wrap is harmless.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            latency_r <= 24'd0;
        end else if (frm.frame_valid && frm.ts_valid) begin
            latency_r <= global_counter - frm.frame_ts;
        end else begin
            latency_r <= latency_r;
        end
    end

    // Capture the source address of every good frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ipv4_ip_r <= 32'd0;
        end else if (frm.frame_valid) begin
            ipv4_ip_r <= frm.frame_srcip;
        end else begin
            ipv4_ip_r <= ipv4_ip_r;
        end
    end

    assign pps        = pps_r;
    assign throughput = throughput_r;
    assign latency    = latency_r;
    assign ipv4_ip    = ipv4_ip_r;
    assign update     = update_r;

endmodule

// File: tb/tb_rx_stats_meter.sv
// Self-checking bench for rx_stats_meter: directed scenarios with literal
// expectations plus randomized traffic against a per-window bin model.
module tb_rx_stats_meter;
    import stats_pkg::*;

    localparam int unsigned W   = 100;
    localparam int unsigned OH  = 20;
    localparam int unsigned W2  = 33000;
    localparam int unsigned OH2 = 65535;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [23:0] gc;
    logic [31:0] pps, thr, ip;
    logic [23:0] lat;
    logic        upd;

    logic        rst2_n;
    logic [23:0] gc2;
    logic [31:0] pps2, thr2, ip2;
    logic [23:0] lat2;
    logic        upd2;
    bit          sat_done = 1'b0;

    rx_stats_meter_if frm ();
    rx_stats_meter_if frm2 ();

    rx_stats_meter #(.WINDOW(W), .OVERHEAD(OH)) dut (
        .clk(clk), .rst_n(rst_n), .frm(frm), .global_counter(gc),
        .pps(pps), .throughput(thr), .latency(lat), .ipv4_ip(ip), .update(upd)
    );

    rx_stats_meter #(.WINDOW(W2), .OVERHEAD(OH2)) dut_sat (
        .clk(clk), .rst_n(rst2_n), .frm(frm2), .global_counter(gc2),
        .pps(pps2), .throughput(thr2), .latency(lat2), .ipv4_ip(ip2), .update(upd2)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model: frames binned by window index ----------------
    longint      m_cnt[int];
    longint      m_bytes[int];
    int          m_t = 0;
    bit          m_live = 1'b0;
    logic [31:0] e_pps, e_thr, e_ip;
    logic [23:0] e_lat;
    logic        e_upd;

    function automatic longint sat32(input longint v);
        if (v > 64'hFFFF_FFFF) return 64'hFFFF_FFFF;
        else return v;
    endfunction

    // Called right after each rising edge with the inputs that edge sampled.
    task automatic model_step();
        int k;
        if (!rst_n) begin
            m_cnt.delete();
            m_bytes.delete();
            m_t = 0;
            e_pps = 32'd0; e_thr = 32'd0; e_lat = 24'd0; e_ip = 32'd0; e_upd = 1'b0;
            m_live = 1'b1;
        end else begin
            e_upd = 1'b0;
            if (frm.frame_valid) begin
                // A frame at cycle t belongs to window floor((t+1)/W).
                k = (m_t + 1) / W;
                m_cnt[k]   = (m_cnt.exists(k) ? m_cnt[k] : 0) + 1;
                m_bytes[k] = (m_bytes.exists(k) ? m_bytes[k] : 0) + longint'(frm.frame_len) + OH;
                e_ip = frm.frame_srcip;
                if (frm.ts_valid) e_lat = gc - frm.frame_ts;
            end
            if ((m_t + 1) % W == 0) begin
                k = (m_t + 1) / W - 1;
                e_pps = 32'(sat32(m_cnt.exists(k) ? m_cnt[k] : 0));
                e_thr = 32'(sat32(m_bytes.exists(k) ? m_bytes[k] : 0));
                e_upd = 1'b1;
            end
            m_t++;
        end
    endtask

    // Compare process: every cycle once the model has seen reset.
    initial begin
        forever begin
            @(negedge clk);
            if (m_live) begin
                check("cyc_pps", pps, e_pps);
                check("cyc_throughput", thr, e_thr);
                check("cyc_latency", lat, e_lat);
                check("cyc_ipv4", ip, e_ip);
                check("cyc_update", upd, e_upd);
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        frm.frame_valid = 1'b0;
        frm.ts_valid    = 1'($urandom);
        frm.frame_len   = 16'($urandom);
        frm.frame_srcip = $urandom;
        frm.frame_ts    = 24'($urandom);
    endtask

    task automatic frame(input logic [15:0] len, input logic [31:0] sip,
                         input logic tsv, input logic [23:0] ts);
        frm.frame_valid = 1'b1;
        frm.frame_len   = len;
        frm.frame_srcip = sip;
        frm.ts_valid    = tsv;
        frm.frame_ts    = ts;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        #1;
        gc = gc + 24'd1;
        idle();
    endtask

    task automatic run_to(input int target);
        while (m_t < target) tick();
    endtask

    // ---------------- saturation instance ----------------
    initial begin
        rst2_n = 1'b0;
        gc2 = 24'd0;
        frm2.frame_valid = 1'b0;
        frm2.frame_len   = 16'hFFFF;
        frm2.frame_srcip = 32'hC0A8_0001;
        frm2.ts_valid    = 1'b0;
        frm2.frame_ts    = 24'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst2_n = 1'b1;
        frm2.frame_valid = 1'b1;
        repeat (W2 - 1) @(posedge clk);
        @(negedge clk);
        check("sat_update_early", upd2, 1'b0);
        @(posedge clk);
        @(negedge clk);
        check("sat_update", upd2, 1'b1);
        check("sat_pps", pps2, 64'(W2 - 1));
        check("sat_throughput", thr2, 64'hFFFF_FFFF);
        sat_done = 1'b1;
    end

    // ---------------- main sequence ----------------
    initial begin
        int prob;
        int sel;
        logic [15:0] len;
        int guard;

        rst_n = 1'b0;
        gc = 24'($urandom);
        idle();
        repeat (3) tick();
        check("rst_pps", pps, 32'd0);
        check("rst_throughput", thr, 32'd0);
        check("rst_update", upd, 1'b0);
        rst_n = 1'b1;

        // Basic window: three 64-byte frames.
        run_to(10); frame(16'd64, 32'h0102_0304, 1'b0, 24'd0); tick();
        run_to(20); frame(16'd64, 32'h0102_0305, 1'b0, 24'd0); tick();
        run_to(30); frame(16'd64, 32'h0102_0306, 1'b0, 24'd0); tick();
        run_to(99);
        check("basic_no_early_update", upd, 1'b0);
        tick();
        check("basic_pps", pps, 32'd3);
        check("basic_throughput", thr, 32'd252);
        check("basic_update", upd, 1'b1);
        run_to(200);
        check("empty_pps", pps, 32'd0);
        check("empty_throughput", thr, 32'd0);

        // Frame exactly on the boundary cycle counts in the next window.
        run_to(299); frame(16'd100, 32'h0A00_0001, 1'b0, 24'd0); tick();
        check("bnd_pps_old", pps, 32'd0);
        check("bnd_update", upd, 1'b1);
        run_to(400);
        check("bnd_pps_new", pps, 32'd1);
        check("bnd_throughput_new", thr, 32'd120);

        // Latency wrap and hold.
        run_to(410);
        gc = 24'h000010;
        frame(16'd64, 32'h0A00_0002, 1'b1, 24'hFFFFF0); tick();
        check("lat_wrap", lat, 24'h000020);
        frame(16'd64, 32'h0A00_0003, 1'b0, 24'($urandom)); tick();
        check("lat_hold", lat, 24'h000020);

        // IP capture.
        run_to(420);
        frame(16'd64, 32'h0A00_1569, 1'b0, 24'd0); tick();
        check("ip_first", ip, 32'h0A00_1569);
        frame(16'd64, 32'h0A00_156A, 1'b0, 24'd0); tick();
        check("ip_second", ip, 32'h0A00_156A);

        // Randomized windows at varying load, including back-to-back frames.
        run_to(500);
        for (int win = 5; win < 25; win++) begin
            case ($urandom_range(0, 3))
                0: prob = 0;
                1: prob = 10;
                2: prob = 50;
                default: prob = 100;
            endcase
            for (int c = 0; c < int'(W); c++) begin
                if ($urandom_range(0, 99) < prob) begin
                    sel = $urandom_range(0, 9);
                    if (sel == 0) len = 16'd0;
                    else if (sel == 1) len = 16'hFFFF;
                    else len = 16'($urandom_range(0, 1600));
                    frame(len, $urandom, 1'($urandom), 24'($urandom));
                end
                if ($urandom_range(0, 15) == 0) gc = 24'($urandom);
                tick();
            end
        end

        // Mid-window reset: five frames, reset at win_cnt 50.
        for (int i = 0; i < 5; i++) begin
            run_to(2505 + i);
            frame(16'd200, 32'hAC10_0001 + 32'(i), 1'b1, 24'($urandom));
            tick();
        end
        run_to(2550);
        rst_n = 1'b0;
        tick();
        check("mrst_pps", pps, 32'd0);
        check("mrst_throughput", thr, 32'd0);
        check("mrst_latency", lat, 24'd0);
        check("mrst_ipv4", ip, 32'd0);
        check("mrst_update", upd, 1'b0);
        rst_n = 1'b1;
        run_to(10); frame(16'd64, 32'h0B00_0001, 1'b0, 24'd0); tick();
        run_to(60); frame(16'd64, 32'h0B00_0002, 1'b0, 24'd0); tick();
        run_to(99);
        check("mrst_no_early_update", upd, 1'b0);
        tick();
        check("mrst_post_pps", pps, 32'd2);
        check("mrst_post_throughput", thr, 32'd168);
        check("mrst_post_update", upd, 1'b1);

        // Let the saturation instance finish, bounded.
        guard = 0;
        while (!sat_done && guard < 40000) begin
            tick();
            guard++;
        end
        check("sat_done", sat_done, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
